// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply and,
// when MULTICYCLE_ALU_DIV_EN is defined, iterative restoring divide. The valid/ready handshake is described at the port list.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  // An operation is accepted on a rising edge with in_valid & in_ready; a result is handed off on
  // a rising edge with out_valid & out_ready. Results stay stable while out_valid is high and
  // the consumer stalls. No new operation is accepted in the edge that completes a handoff.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Control_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero,
  output logic [1:0]       state_o
);

  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH:0]   hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             hi_sel_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH-1:0] multi_res;
  logic [WIDTH-1:0] single_res;

`ifdef MULTICYCLE_ALU_DIV_EN
  logic [WIDTH-1:0] b_q;
  logic             is_div_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
`endif

  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [SH_W-1:0] sh;
    sh = b[SH_W-1:0];
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0011: return a;
      4'b0100: return a ^ b;
      4'b0101: return a << sh;
      4'b0111: return {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1000: return {{(WIDTH-1){1'b0}}, a < b};
      4'b1001: return a >> sh;
      4'b1010: return $signed(a) >>> sh;
      default: return '0;
    endcase
  endfunction

  function automatic logic is_multi(input logic [3:0] op);
`ifdef MULTICYCLE_ALU_DIV_EN
    return op[3:2] == 2'b11;
`else
    return op[3:1] == 3'b110;
`endif
  endfunction

  assign single_res = alu_single(Control_in, A, B);

  // One iteration per BUSY cycle; hi/lo hold {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum = hi_q + {1'b0, (lo_q[0] ? a_q : {WIDTH{1'b0}})};
    hi_d    = {1'b0, mul_sum[WIDTH:1]};
    lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef MULTICYCLE_ALU_DIV_EN
    rem_sh  = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    trial   = {1'b0, rem_sh} - {2'b00, b_q};
    if (is_div_q) begin
      if (trial[WIDTH+1]) begin
        hi_d = rem_sh;
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_d = trial[WIDTH:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end
    end
`endif
    multi_res = hi_sel_q ? hi_d[WIDTH-1:0] : lo_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_sel_q <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
`ifdef MULTICYCLE_ALU_DIV_EN
      b_q      <= '0;
      is_div_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            hi_sel_q <= Control_in[0];
            cnt_q    <= '0;
            hi_q     <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
            b_q      <= B;
            is_div_q <= Control_in[1];
            lo_q     <= Control_in[1] ? A : B;
`else
            lo_q     <= B;
`endif
            if (is_multi(Control_in)) begin
              state_q <= BUSY;
            end else begin
              result_q <= single_res;
              zero_q   <= (single_res == '0);
              state_q  <= DONE;
            end
          end
        end
        BUSY: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            cnt_q    <= '0;
            result_q <= multi_res;
            zero_q   <= (multi_res == '0);
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign ALU_result = result_q;
  assign zero       = zero_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32): vector table, randomized ops against an
// arithmetic reference model, and hand sequences for backpressure and reset corner cases.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic [3:0]  Control_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALU_result;
  logic        zero;
  logic [1:0]  state_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  multicycle_alu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Control_in(Control_in), .out_valid(out_valid),
    .out_ready(out_ready), .ALU_result(ALU_result), .zero(zero), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        z;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic [3:0] op, input logic [31:0] a, b, res, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.z = (res == 32'd0); v.lat = lat;
    vecs.push_back(v);
  endfunction

  // Reference model: plain arithmetic on 64-bit products and native division.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, b,
                                  output logic [31:0] r, output int lat);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    lat = 1;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd6:  r = a - b;
      4'd3:  r = a;
      4'd4:  r = a ^ b;
      4'd5:  r = a << b[4:0];
      4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  r = (a < b) ? 32'd1 : 32'd0;
      4'd9:  r = a >> b[4:0];
      4'd10: r = $signed(a) >>> b[4:0];
      4'd12: begin r = p[31:0];  lat = 33; end
      4'd13: begin r = p[63:32]; lat = 33; end
`ifdef MULTICYCLE_ALU_DIV_EN
      4'd14: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = 33; end
      4'd15: begin r = (b == 0) ? a : a % b;              lat = 33; end
`endif
      default: r = 32'd0;
    endcase
  endfunction

  // Issue one op with out_ready=1; returns result, zero and cycles from accept to out_valid.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, b,
                       output logic [31:0] r, output logic z, output int lat);
    bit busy_ok;
    busy_ok = 1;
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    A = a; B = b; Control_in = op; in_valid = 1; out_ready = 1;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 0; A = $urandom; B = $urandom; Control_in = 4'($urandom);
      lat++;
      if (!out_valid && in_ready) busy_ok = 0;
    end while (!out_valid && lat < 200);
    r = ALU_result; z = zero;
    if (lat > 1) check("in_ready_low_in_busy", busy_ok, 1);
  endtask

  initial begin
    logic [31:0] r, e, held;
    logic        z;
    int          lat, elat;
    bit          seen;

    reset = 1; in_valid = 0; out_ready = 1; A = 0; B = 0; Control_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", ALU_result, 0);
    check("reset_zero", zero, 1);
    reset = 0;

    add_vec(4'd2,  32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    add_vec(4'd6,  32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    add_vec(4'd7,  32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    add_vec(4'd8,  32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    add_vec(4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
    add_vec(4'd1,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1);
    add_vec(4'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
    add_vec(4'd3,  32'h1234_5678, 32'd9, 32'h1234_5678, 1);
    add_vec(4'd5,  32'd1, 32'h24, 32'h10, 1);
    add_vec(4'd9,  32'h8000_0000, 32'd31, 32'd1, 1);
    add_vec(4'd10, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    add_vec(4'd11, 32'h1234_5678, 32'h1, 32'd0, 1);
    add_vec(4'd12, 32'h0001_0000, 32'h0001_0000, 32'd0, 33);
    add_vec(4'd13, 32'h0001_0000, 32'h0001_0000, 32'd1, 33);
    add_vec(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);
    add_vec(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
`ifdef MULTICYCLE_ALU_DIV_EN
    add_vec(4'd14, 32'd100, 32'd7, 32'd14, 33);
    add_vec(4'd15, 32'd100, 32'd7, 32'd2, 33);
    add_vec(4'd14, 32'd100, 32'd0, 32'hFFFF_FFFF, 33);
    add_vec(4'd15, 32'd100, 32'd0, 32'd100, 33);
`else
    add_vec(4'd14, 32'd100, 32'd7, 32'd0, 1);
    add_vec(4'd15, 32'd100, 32'd7, 32'd0, 1);
`endif

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].res);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat);
      e = exp_q.pop_front();
      check($sformatf("vec%0d_op%0d_result", i, vecs[i].op), r, e);
      check($sformatf("vec%0d_op%0d_zero", i, vecs[i].op), z, vecs[i].z);
      check($sformatf("vec%0d_op%0d_latency", i, vecs[i].op), lat, vecs[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      ref_alu(op, a, b, e, elat);
      exp_q.push_back(e);
      do_op(op, a, b, r, z, lat);
      e = exp_q.pop_front();
      check($sformatf("rand%0d_op%0d_result", i, op), r, e);
      check($sformatf("rand%0d_op%0d_zero", i, op), z, e == 32'd0);
      check($sformatf("rand%0d_op%0d_latency", i, op), lat, elat);
    end

    // Backpressure: result held while the consumer stalls and in_valid is ignored.
    @(negedge clk);
    A = 32'hF0; B = 32'h0F; Control_in = 4'd1; in_valid = 1; out_ready = 0;
    @(negedge clk);
    check("bp_out_valid", out_valid, 1);
    check("bp_result", ALU_result, 32'hFF);
    A = 32'd2; B = 32'd3; Control_in = 4'd2;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!out_valid || in_ready || ALU_result !== 32'hFF || zero !== 1'b0) seen = 1;
    end
    check("bp_held_stable", seen, 0);
    out_ready = 1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_no_accept", out_valid, 0);
    check("bp_result_unchanged", ALU_result, 32'hFF);
    in_valid = 0;

    // Reset during the 10th BUSY cycle of a MUL abandons it.
    @(negedge clk);
    A = 32'h0001_0000; B = 32'h0001_0000; Control_in = 4'd12; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (9) @(negedge clk);
    check("mid_mul_busy", in_ready, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("mid_mul_reset_in_ready", in_ready, 1);
    check("mid_mul_reset_result", ALU_result, 0);
    check("mid_mul_reset_zero", zero, 1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("mid_mul_no_out_valid", seen, 0);
    do_op(4'd2, 32'd2, 32'd3, r, z, lat);
    check("post_reset_add", r, 32'd5);
    check("post_reset_add_zero", z, 0);

    // Reset wins over a simultaneous accept.
    @(negedge clk);
    @(negedge clk);
    A = 32'd1; B = 32'd1; Control_in = 4'd2; in_valid = 1; reset = 1;
    @(negedge clk);
    reset = 0; in_valid = 0;
    check("reset_prio_out_valid", out_valid, 0);
    check("reset_prio_result", ALU_result, 0);
    @(negedge clk);
    check("reset_prio_still_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 8..64, even).
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width (SHALL satisfy 2^CNT_W > WIDTH).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands/op presented.
REQ-006 in_ready  output  1  block can accept a new operation.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Control_in  input  4  operation code.
REQ-010 out_valid  output  1  ALU_result/zero valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 ALU_result  output  WIDTH  registered result.
REQ-013 zero  output  1  registered flag, 1 iff ALU_result == 0.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-015 Accept = in_valid & in_ready at a rising edge; A, B, Control_in SHALL be captured into internal registers on accept and inputs ignored otherwise.
REQ-016 Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 PASS_A, 0100 XOR, 0101 SLL, 0111 SLT (signed), 1000 SLTU, 1001 SRL, 1010 SRA, 1100 MUL (low WIDTH bits), 1101 MULHU (high WIDTH bits, unsigned), 1110 DIVU, 1111 REMU; any other code yields result 0.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; shifts SHALL use B[log2(WIDTH)-1:0] as amount; SLT/SLTU results SHALL be 0 or 1 zero-extended.
REQ-018 Single-cycle ops (all except MUL, MULHU, DIVU, REMU): IDLE -> DONE on accept; out_valid SHALL be 1 in the cycle after accept.
REQ-019 MUL/MULHU: IDLE -> BUSY on accept; unsigned shift-add, one bit of B per cycle, exactly WIDTH BUSY cycles, then DONE; out_valid first high WIDTH+1 cycles after accept.
REQ-020 DIVU/REMU: restoring division, one quotient bit per cycle, exactly WIDTH BUSY cycles, same latency as REQ-019.
REQ-021 Divide by zero SHALL give DIVU = all ones, REMU = A, with normal latency.
REQ-022 DONE: ALU_result and zero held stable while out_valid=1 and out_ready=0; DONE -> IDLE on out_valid & out_ready.
REQ-023 No new operation SHALL be accepted in the cycle of result handoff; earliest next accept is the following cycle (in IDLE).
REQ-024 ALU_result and zero SHALL change only on the DONE-entry edge or reset.
REQ-025 Counter SHALL count 0..WIDTH-1 in BUSY and SHALL clear on every accept.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, in_ready=1, out_valid=0, ALU_result=0, zero=1, counter=0, regardless of state.
REQ-027 reset during BUSY or DONE SHALL abandon the operation; no out_valid for it SHALL ever be produced.
REQ-028 reset SHALL take priority over accept and handoff in the same cycle.

Configuration
REQ-029 Macro MULTICYCLE_ALU_DIV_EN: when defined, DIVU/REMU SHALL behave per REQ-020/021.
REQ-030 When MULTICYCLE_ALU_DIV_EN is undefined, divider logic SHALL be absent and codes 1110/1111 SHALL behave as undefined codes (result 0, zero=1, single-cycle latency).

Verification
REQ-031 WIDTH=32: reset, then ADD A=0xFFFFFFFF B=1 -> out_valid next cycle, ALU_result=0, zero=1.
REQ-032 SUB A=5 B=7 -> 0xFFFFFFFE, zero=0; SLT A=0xFFFFFFFF B=1 -> 1; SLTU same operands -> 0.
REQ-033 MUL A=0x10000 B=0x10000 -> ALU_result=0, zero=1 after 33 cycles; MULHU same -> 0x1; in_ready=0 throughout BUSY.
REQ-034 DIV_EN defined: DIVU A=100 B=7 -> 14, REMU -> 2; DIVU B=0 -> 0xFFFFFFFF, REMU B=0 -> 100; undefined: DIVU A=100 B=7 -> 0, 1-cycle latency.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles after result of OR 0xF0 | 0x0F -> 0xFF stable, in_valid ignored; release -> IDLE next cycle.
REQ-036 Assert reset mid-MUL (cycle 10 of BUSY) -> IDLE, out_valid never asserted for that op, next ADD 2+3 -> 5.
